// File: rtl/reg_file_sb.sv
// reg_file_sb: scoreboarded integer register file for the pipelined RISC-V datapath.
//
// Two combinational read ports, one synchronous write port, and x0 hardwired to zero.
// Optionally, write data is bypassed to matching read ports. Each register has a
// saturating pending-write counter that tracks in-flight producers, and decode uses it
// to stall on RAW hazards.
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   rst_n               synchronous active-low reset (clears registers and counters)
//   A1, A2 / RD1, RD2   read addresses / read data (combinational)
//   WE, A3, WD          writeback enable / address / data
//   Issue_en, Issue_rd  decode issues a producer for Issue_rd
//   Issue_ok            issue accepted (counter for Issue_rd not saturated)
//   Flush               clear all pending counters
//   Stall               RAW hazard on A1 or A2
module reg_file_sb #(
    parameter int unsigned Reg_size   = 32,
    parameter int unsigned Num_of_reg = 32,
    parameter int unsigned Addr_bits  = 5,
    parameter int unsigned Cnt_bits   = 2,
    parameter int unsigned Bypass     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic        [Addr_bits-1:0] A1,
    input  logic        [Addr_bits-1:0] A2,
    output logic signed [Reg_size-1:0]  RD1,
    output logic signed [Reg_size-1:0]  RD2,
    input  logic                       WE,
    input  logic        [Addr_bits-1:0] A3,
    input  logic signed [Reg_size-1:0]  WD,
    input  logic                       Issue_en,
    input  logic        [Addr_bits-1:0] Issue_rd,
    output logic                       Issue_ok,
    input  logic                       Flush,
    output logic                       Stall
);

    // x0 has no storage; the arrays start at index 1.
    logic [Reg_size-1:0] rf_q  [1:Num_of_reg-1];
    logic [Cnt_bits-1:0] cnt_q [1:Num_of_reg-1];
    logic [Cnt_bits-1:0] cnt_d [1:Num_of_reg-1];

    // A lookup is valid only for addresses 1..Num_of_reg-1. Anything else acts like x0.
    logic                v1, v2, v_iss;
    logic [Reg_size-1:0] rd1_reg, rd2_reg;
    logic [Cnt_bits-1:0] cnt1, cnt2, cnt_iss;
    logic                byp1, byp2, hz1, hz2;

    always_comb begin
        v1      = 1'b0;
        v2      = 1'b0;
        v_iss   = 1'b0;
        rd1_reg = '0;
        rd2_reg = '0;
        cnt1    = '0;
        cnt2    = '0;
        cnt_iss = '0;
        for (int r = 1; r < int'(Num_of_reg); r++) begin
            if (A1 == Addr_bits'(r)) begin
                v1      = 1'b1;
                rd1_reg = rf_q[r];
                cnt1    = cnt_q[r];
            end
            if (A2 == Addr_bits'(r)) begin
                v2      = 1'b1;
                rd2_reg = rf_q[r];
                cnt2    = cnt_q[r];
            end
            if (Issue_rd == Addr_bits'(r)) begin
                v_iss   = 1'b1;
                cnt_iss = cnt_q[r];
            end
        end
    end

    always_comb begin
        byp1 = (Bypass != 0) && WE && (A3 == A1) && v1;
        byp2 = (Bypass != 0) && WE && (A3 == A2) && v2;
        RD1  = v1 ? (byp1 ? WD : $signed(rd1_reg)) : '0;
        RD2  = v2 ? (byp2 ? WD : $signed(rd2_reg)) : '0;
        // If the last outstanding producer is writing back now, the bypass covers it.
        hz1  = v1 && (cnt1 != '0) && !(byp1 && (cnt1 == Cnt_bits'(1)));
        hz2  = v2 && (cnt2 != '0) && !(byp2 && (cnt2 == Cnt_bits'(1)));
        Stall    = rst_n && (hz1 || hz2);
        Issue_ok = !rst_n || !(Issue_en && v_iss && (&cnt_iss));
    end

    // Counter next state. A same-cycle issue and writeback cancel each other out.
    always_comb begin
        for (int r = 1; r < int'(Num_of_reg); r++) begin
            logic inc, dec;
            inc = Issue_en && Issue_ok && (Issue_rd == Addr_bits'(r));
            dec = WE && (A3 == Addr_bits'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (Flush) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + Cnt_bits'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - Cnt_bits'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 1; r < int'(Num_of_reg); r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < int'(Num_of_reg); r++) begin
                if (WE && (A3 == Addr_bits'(r))) begin
                    rf_q[r] <= WD;
                end
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule
